scc_mem_arbiter: RTL and testbench

SCC_MEM_ARBITER -- requirements
Module: scc_mem_arbiter

---
 rtl/scc_mem_arbiter.sv | 178 +++++++++++++++++
 tb/tb_scc_mem_arbiter.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/scc_mem_arbiter.sv
// ============================================================================
//  Module   : scc_mem_arbiter
//  Brief    : Two-requester (fetch/data) arbiter onto one shared memory port,
//             with bounded data-burst fairness, halt handling and error flags.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module scc_mem_arbiter #(
    parameter int MEM_LAT        = 1,
    parameter int MAX_DATA_BURST = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clk_en,
    input  logic        halt_f,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ack,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ack,
    output logic [31:0] d_rdata,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        busy,
    output logic        halted,
    output logic [1:0]  err_bits
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACK    = 2'd2,
        ST_HALTED = 2'd3
    } state_t;

    localparam logic [2:0] c_lat       = 3'(MEM_LAT);
    localparam logic [3:0] c_max_burst = 4'(MAX_DATA_BURST);

    state_t      r_state,     w_state_nxt;
    logic [2:0]  r_cnt,       w_cnt_nxt;
    logic [3:0]  r_streak,    w_streak_nxt;
    logic        r_halt_pend, w_halt_nxt;
    logic        r_grant_d,   w_grant_d_nxt;
    logic        r_mem_en_q,  w_mem_en_nxt;
    logic        r_mem_we,    w_mem_we_nxt;
    logic [31:0] r_mem_addr,  w_mem_addr_nxt;
    logic [31:0] r_mem_wdata, w_mem_wdata_nxt;
    logic [31:0] r_if_rdata,  w_if_rdata_nxt;
    logic [31:0] r_d_rdata,   w_d_rdata_nxt;
    logic [1:0]  r_err_bits,  w_err_nxt;
    logic        w_pick_d;

    // Fetch addresses are word-aligned by construction; their low bits carry no meaning.
    logic        w_unused;
    assign w_unused = ^if_addr[1:0];

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_streak_nxt    = r_streak;
        w_halt_nxt      = r_halt_pend;
        w_grant_d_nxt   = r_grant_d;
        w_mem_en_nxt    = 1'b0;
        w_mem_we_nxt    = r_mem_we;
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_wdata_nxt = r_mem_wdata;
        w_if_rdata_nxt  = r_if_rdata;
        w_d_rdata_nxt   = r_d_rdata;
        w_err_nxt       = r_err_bits;
        // Data has priority unless it has already won MAX_DATA_BURST contended rounds.
        w_pick_d        = d_req && !(if_req && (r_streak == c_max_burst));

        case (r_state)
            ST_IDLE: begin
                if (halt_f) begin
                    w_state_nxt = ST_HALTED;
                end else if (if_req || d_req) begin
                    w_state_nxt  = ST_WAIT;
                    w_cnt_nxt    = c_lat;
                    w_mem_en_nxt = 1'b1;
                    if (w_pick_d) begin
                        w_grant_d_nxt   = 1'b1;
                        w_mem_we_nxt    = d_we;
                        w_mem_addr_nxt  = {d_addr[31:2], 2'b00};
                        w_mem_wdata_nxt = d_wdata;
                        w_streak_nxt    = if_req ? (r_streak + 4'd1) : 4'd0;
                        if (d_addr[1:0] != 2'b00) begin
                            w_err_nxt[1] = 1'b1;
                        end
                    end else begin
                        w_grant_d_nxt   = 1'b0;
                        w_mem_we_nxt    = 1'b0;
                        w_mem_addr_nxt  = {if_addr[31:2], 2'b00};
                        w_mem_wdata_nxt = 32'd0;
                        w_streak_nxt    = 4'd0;
                    end
                end
            end
            ST_WAIT: begin
                w_halt_nxt = r_halt_pend | halt_f;
                w_cnt_nxt  = r_cnt - 3'd1;
                if (r_cnt == 3'd1) begin
                    w_state_nxt = ST_ACK;
                    if (r_grant_d) begin
                        w_d_rdata_nxt = r_mem_we ? 32'd0 : mem_rdata;
                    end else begin
                        w_if_rdata_nxt = mem_rdata;
                    end
                end
            end
            ST_ACK: begin
                w_state_nxt = (r_halt_pend || halt_f) ? ST_HALTED : ST_IDLE;
            end
            ST_HALTED: begin
                if (if_req || d_req) begin
                    w_err_nxt[0] = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= 3'd0;
            r_streak    <= 4'd0;
            r_halt_pend <= 1'b0;
            r_grant_d   <= 1'b0;
            r_mem_en_q  <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= 32'd0;
            r_mem_wdata <= 32'd0;
            r_if_rdata  <= 32'd0;
            r_d_rdata   <= 32'd0;
            r_err_bits  <= 2'b00;
        end else if (clk_en) begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_streak    <= w_streak_nxt;
            r_halt_pend <= w_halt_nxt;
            r_grant_d   <= w_grant_d_nxt;
            r_mem_en_q  <= w_mem_en_nxt;
            r_mem_we    <= w_mem_we_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_wdata <= w_mem_wdata_nxt;
            r_if_rdata  <= w_if_rdata_nxt;
            r_d_rdata   <= w_d_rdata_nxt;
            r_err_bits  <= w_err_nxt;
        end
    end

    // The strobe is qualified by clk_en so a stalled cycle never issues a memory access.
    assign mem_en    = r_mem_en_q & clk_en;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign if_ack    = (r_state == ST_ACK) & ~r_grant_d;
    assign d_ack     = (r_state == ST_ACK) &  r_grant_d;
    assign if_rdata  = r_if_rdata;
    assign d_rdata   = r_d_rdata;
    assign busy      = (r_state == ST_WAIT) | (r_state == ST_ACK);
    assign halted    = (r_state == ST_HALTED);
    assign err_bits  = r_err_bits;

endmodule

`default_nettype wire

// File: tb/tb_scc_mem_arbiter.sv
// ============================================================================
//  Module   : tb_scc_mem_arbiter
//  Brief    : Directed vector table plus hand-written multi-cycle sequences.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_scc_mem_arbiter;

    localparam logic H = 1'b1;
    localparam logic L = 1'b0;

    logic        clk = 1'b0;
    logic        rst, clk_en, halt_f, if_req, d_req, d_we;
    logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;

    logic        a_if_ack, a_d_ack, a_mem_en, a_mem_we, a_busy, a_halted;
    logic [31:0] a_if_rdata, a_d_rdata, a_mem_addr, a_mem_wdata;
    logic [1:0]  a_err_bits;
    logic        b_if_ack, b_d_ack, b_mem_en, b_mem_we, b_busy, b_halted;
    logic [31:0] b_if_rdata, b_d_rdata, b_mem_addr, b_mem_wdata;
    logic [1:0]  b_err_bits;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    scc_mem_arbiter #(.MEM_LAT(1), .MAX_DATA_BURST(3)) u_dut_a (
        .clk(clk), .rst(rst), .clk_en(clk_en), .halt_f(halt_f),
        .if_req(if_req), .if_addr(if_addr), .if_ack(a_if_ack), .if_rdata(a_if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(a_d_ack), .d_rdata(a_d_rdata),
        .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr),
        .mem_wdata(a_mem_wdata), .mem_rdata(mem_rdata),
        .busy(a_busy), .halted(a_halted), .err_bits(a_err_bits)
    );

    scc_mem_arbiter #(.MEM_LAT(2), .MAX_DATA_BURST(3)) u_dut_b (
        .clk(clk), .rst(rst), .clk_en(clk_en), .halt_f(halt_f),
        .if_req(if_req), .if_addr(if_addr), .if_ack(b_if_ack), .if_rdata(b_if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(b_d_ack), .d_rdata(b_d_rdata),
        .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
        .mem_wdata(b_mem_wdata), .mem_rdata(mem_rdata),
        .busy(b_busy), .halted(b_halted), .err_bits(b_err_bits)
    );

    typedef struct {
        logic        rst, ce, hf, ifr;
        logic [31:0] ifa;
        logic        dr, dwe;
        logic [31:0] da, dwd, mrd;
        logic        e_ifack, e_dack, e_men, e_mwe;
        logic [31:0] e_maddr, e_mwd;
        logic        e_busy, e_hlt;
        logic [1:0]  e_err;
        logic [31:0] e_ifrd, e_drd;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        halt_f = L; if_req = L; if_addr = 32'd0; d_req = L; d_we = L;
        d_addr = 32'd0; d_wdata = 32'd0; mem_rdata = 32'd0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        rst = H; clk_en = H;
        @(posedge clk);
        #1;
        @(negedge clk);
        rst = L;
    endtask

    initial begin
        int   n_gnt;
        int   n_edges;
        int   gnt_edge[8];
        logic gnt_d[8];
        logic exp_d[8];

        rst = H; clk_en = H;
        idle_inputs();

        //          rst ce hf ifr ifa           dr dwe da            dwd           mrd            | ack_i ack_d men mwe maddr        mwd           busy hlt err    ifrd          drd
        vecs[0]  = '{H, H, L, L, 32'h0,        L, L, 32'h0,        32'h0,        32'h0,         L, L, L, L, 32'h0,        32'h0,        L, L, 2'b00, 32'h0,        32'h0};
        vecs[1]  = '{L, H, L, H, 32'h40,       L, L, 32'h0,        32'h0,        32'h12345678,  L, L, H, L, 32'h40,       32'h0,        H, L, 2'b00, 32'h0,        32'h0};
        vecs[2]  = '{L, H, L, H, 32'h40,       L, L, 32'h0,        32'h0,        32'h12345678,  H, L, L, L, 32'h40,       32'h0,        H, L, 2'b00, 32'h12345678, 32'h0};
        vecs[3]  = '{L, H, L, L, 32'h40,       L, L, 32'h0,        32'h0,        32'h12345678,  L, L, L, L, 32'h40,       32'h0,        L, L, 2'b00, 32'h12345678, 32'h0};
        vecs[4]  = '{L, H, L, L, 32'h0,        H, H, 32'h103,      32'hCAFEF00D, 32'hDEADBEEF,  L, L, H, H, 32'h100,      32'hCAFEF00D, H, L, 2'b10, 32'h12345678, 32'h0};
        vecs[5]  = '{L, H, L, L, 32'h0,        H, H, 32'h103,      32'hCAFEF00D, 32'hDEADBEEF,  L, H, L, H, 32'h100,      32'hCAFEF00D, H, L, 2'b10, 32'h12345678, 32'h0};
        vecs[6]  = '{L, H, L, L, 32'h0,        L, L, 32'h0,        32'h0,        32'hDEADBEEF,  L, L, L, H, 32'h100,      32'hCAFEF00D, L, L, 2'b10, 32'h12345678, 32'h0};
        vecs[7]  = '{L, H, L, L, 32'h0,        H, L, 32'h200,      32'h0,        32'hA5A50001,  L, L, H, L, 32'h200,      32'h0,        H, L, 2'b10, 32'h12345678, 32'h0};
        vecs[8]  = '{L, H, H, L, 32'h0,        H, L, 32'h200,      32'h0,        32'hA5A50001,  L, H, L, L, 32'h200,      32'h0,        H, L, 2'b10, 32'h12345678, 32'hA5A50001};
        vecs[9]  = '{L, H, L, L, 32'h0,        L, L, 32'h0,        32'h0,        32'hA5A50001,  L, L, L, L, 32'h200,      32'h0,        L, H, 2'b10, 32'h12345678, 32'hA5A50001};
        vecs[10] = '{L, H, L, H, 32'h80,       L, L, 32'h0,        32'h0,        32'h0,         L, L, L, L, 32'h200,      32'h0,        L, H, 2'b11, 32'h12345678, 32'hA5A50001};
        vecs[11] = '{L, H, L, H, 32'h80,       L, L, 32'h0,        32'h0,        32'h0,         L, L, L, L, 32'h200,      32'h0,        L, H, 2'b11, 32'h12345678, 32'hA5A50001};
        vecs[12] = '{H, H, L, L, 32'h0,        L, L, 32'h0,        32'h0,        32'h0,         L, L, L, L, 32'h0,        32'h0,        L, L, 2'b00, 32'h0,        32'h0};
        vecs[13] = '{L, H, H, H, 32'h80,       H, L, 32'h204,      32'h0,        32'h0,         L, L, L, L, 32'h0,        32'h0,        L, H, 2'b00, 32'h0,        32'h0};
        vecs[14] = '{L, H, L, H, 32'h80,       L, L, 32'h0,        32'h0,        32'h0,         L, L, L, L, 32'h0,        32'h0,        L, H, 2'b01, 32'h0,        32'h0};

        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            rst = vecs[i].rst; clk_en = vecs[i].ce; halt_f = vecs[i].hf;
            if_req = vecs[i].ifr; if_addr = vecs[i].ifa;
            d_req = vecs[i].dr; d_we = vecs[i].dwe; d_addr = vecs[i].da;
            d_wdata = vecs[i].dwd; mem_rdata = vecs[i].mrd;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_ctl", i),
                  {24'd0, a_if_ack, a_d_ack, a_mem_en, a_mem_we, a_busy, a_halted, a_err_bits},
                  {24'd0, vecs[i].e_ifack, vecs[i].e_dack, vecs[i].e_men, vecs[i].e_mwe,
                   vecs[i].e_busy, vecs[i].e_hlt, vecs[i].e_err});
            check($sformatf("vec%0d_mem_addr", i),  a_mem_addr,  vecs[i].e_maddr);
            check($sformatf("vec%0d_mem_wdata", i), a_mem_wdata, vecs[i].e_mwd);
            check($sformatf("vec%0d_if_rdata", i),  a_if_rdata,  vecs[i].e_ifrd);
            check($sformatf("vec%0d_d_rdata", i),   a_d_rdata,   vecs[i].e_drd);
        end

        // Contended burst: expect D,D,D,F repeating, one grant every 3 cycles.
        do_reset();
        if_req = H; if_addr = 32'h400; d_req = H; d_we = L; d_addr = 32'h800;
        mem_rdata = 32'h55AA55AA;
        exp_d = '{H, H, H, L, H, H, H, L};
        n_gnt = 0;
        for (int cyc = 1; cyc <= 60 && n_gnt < 8; cyc++) begin
            @(posedge clk);
            #1;
            if (a_mem_en) begin
                gnt_d[n_gnt]    = (a_mem_addr == 32'h800);
                gnt_edge[n_gnt] = cyc;
                n_gnt++;
            end
        end
        check("burst_grant_count", n_gnt, 8);
        for (int k = 0; k < n_gnt; k++) begin
            check($sformatf("burst_order%0d", k), {31'd0, gnt_d[k]}, {31'd0, exp_d[k]});
            if (k > 0) begin
                check($sformatf("burst_spacing%0d", k), gnt_edge[k] - gnt_edge[k-1], 3);
            end
        end

        // MEM_LAT=2 instance: stall the clock enable for 3 cycles right after a grant.
        do_reset();
        d_req = H; d_we = L; d_addr = 32'h300; mem_rdata = 32'h0BADCAFE;
        @(posedge clk);
        #1;
        check("stall_grant_mem_en", {31'd0, b_mem_en}, 32'd1);
        @(negedge clk);
        clk_en = L;
        #1;
        check("stall_mem_en_gated", {31'd0, b_mem_en}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("stall_frozen%0d", k),
                  {27'd0, b_mem_en, b_busy, b_d_ack, b_err_bits}, {27'd0, 1'b0, 1'b1, 1'b0, 2'b00});
            check($sformatf("stall_addr%0d", k), b_mem_addr, 32'h300);
        end
        @(negedge clk);
        clk_en = H;
        #1;
        check("stall_mem_en_resumed", {31'd0, b_mem_en}, 32'd1);
        n_edges = 3;
        while (!b_d_ack && n_edges < 12) begin
            @(posedge clk);
            #1;
            n_edges++;
        end
        check("stall_ack_latency", n_edges, 5);
        check("stall_d_rdata", b_d_rdata, 32'h0BADCAFE);

        // Reset with clk_en low while a fetch is in WAIT.
        do_reset();
        if_req = H; if_addr = 32'h500; mem_rdata = 32'h11112222;
        @(posedge clk);
        #1;
        check("rstwait_busy", {31'd0, b_busy}, 32'd1);
        @(negedge clk);
        clk_en = L; rst = H;
        @(posedge clk);
        #1;
        check("rstwait_ctl",
              {25'd0, b_if_ack, b_d_ack, b_mem_en, b_mem_we, b_busy, b_halted, b_err_bits}, 32'd0);
        check("rstwait_mem_addr", b_mem_addr, 32'd0);
        check("rstwait_if_rdata", b_if_rdata, 32'd0);
        @(negedge clk);
        rst = L; clk_en = H;
        @(posedge clk);
        #1;
        check("rstwait_regrant_en", {31'd0, b_mem_en}, 32'd1);
        check("rstwait_regrant_addr", b_mem_addr, 32'h500);
        n_edges = 1;
        while (!b_if_ack && n_edges < 12) begin
            @(posedge clk);
            #1;
            n_edges++;
        end
        check("rstwait_ack_latency", n_edges, 3);
        check("rstwait_if_rdata_after", b_if_rdata, 32'h11112222);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
